// File: rtl/bexkat1_pkg.sv
// Shared bexkat1 definitions: branch condition codes and CCR bit layout.
// Used by the writeback stage and by anything that needs to evaluate branches.
package bexkat1_pkg;

  localparam logic [3:0] COND_BRA   = 4'd0;
  localparam logic [3:0] COND_BEQ   = 4'd1;
  localparam logic [3:0] COND_BNE   = 4'd2;
  localparam logic [3:0] COND_BLTU  = 4'd3;
  localparam logic [3:0] COND_BGTU  = 4'd4;
  localparam logic [3:0] COND_BLEU  = 4'd5;
  localparam logic [3:0] COND_BGEU  = 4'd6;
  localparam logic [3:0] COND_BLT   = 4'd7;
  localparam logic [3:0] COND_BGT   = 4'd8;
  localparam logic [3:0] COND_BLE   = 4'd9;
  localparam logic [3:0] COND_BGE   = 4'd10;
  localparam logic [3:0] COND_NEVER = 4'd15;

  localparam int CCR_C = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_N = 1;
  localparam int CCR_V = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic n, input logic v);
    logic [3:0] f;
    f        = '0;
    f[CCR_C] = c;
    f[CCR_Z] = z;
    f[CCR_N] = n;
    f[CCR_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/bexkat1_cond.sv
// Combinational branch-condition evaluator: condition code plus {C,Z,N,V} -> taken.
// C is the borrow after SUB, so the unsigned compares use C directly.
module bexkat1_cond
  import bexkat1_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic c, z, n, v, lt;

  assign c  = flags_i[CCR_C];
  assign z  = flags_i[CCR_Z];
  assign n  = flags_i[CCR_N];
  assign v  = flags_i[CCR_V];
  assign lt = n ^ v;

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_BRA:  taken_o = 1'b1;
      COND_BEQ:  taken_o = z;
      COND_BNE:  taken_o = ~z;
      COND_BLTU: taken_o = c;
      COND_BGTU: taken_o = ~c & ~z;
      COND_BLEU: taken_o = c | z;
      COND_BGEU: taken_o = ~c;
      COND_BLT:  taken_o = lt;
      COND_BGT:  taken_o = ~z & ~lt;
      COND_BLE:  taken_o = z | lt;
      COND_BGE:  taken_o = ~lt;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_wb.sv
// ALU writeback stage: captures result/flags, maintains the CCR, resolves branches
// and hands entries downstream through a two-entry (main + skid) valid/ready buffer.
module alu_wb
  import bexkat1_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_c,
  input  logic             in_z,
  input  logic             in_n,
  input  logic             in_v,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_wr_reg,
  input  logic             in_set_flags,
  input  logic             in_is_branch,
  input  logic [3:0]       in_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [REGW-1:0]  out_rd,
  output logic             out_wr_reg,
  output logic             out_taken,
  output logic [3:0]       ccr_o
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_result_q, main_result_d;
  logic [REGW-1:0]  main_rd_q, main_rd_d;
  logic             main_wr_q, main_wr_d;
  logic             main_taken_q, main_taken_d;

  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic [REGW-1:0]  skid_rd_q, skid_rd_d;
  logic             skid_wr_q, skid_wr_d;
  logic             skid_taken_q, skid_taken_d;

  logic [3:0]       ccr_q, ccr_d;

  logic [3:0]       in_flags, eff_flags;
  logic             cond_true, in_taken;
  logic             accept, xfer;

  assign in_flags  = pack_flags(in_c, in_z, in_n, in_v);
  // A branch that also sets flags is judged on its own flags, not the stale CCR.
  assign eff_flags = in_set_flags ? in_flags : ccr_q;

  bexkat1_cond u_cond (
    .cond_i  (in_cond),
    .flags_i (eff_flags),
    .taken_o (cond_true)
  );

  assign in_taken = in_is_branch & cond_true;
  assign in_ready = ~skid_valid_q & ~rst_i & ~flush_i;
  assign accept   = in_valid & in_ready;
  assign xfer     = main_valid_q & out_ready;

  always_comb begin
    main_valid_d  = main_valid_q;
    main_result_d = main_result_q;
    main_rd_d     = main_rd_q;
    main_wr_d     = main_wr_q;
    main_taken_d  = main_taken_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_rd_d     = skid_rd_q;
    skid_wr_d     = skid_wr_q;
    skid_taken_d  = skid_taken_q;
    ccr_d         = (accept & in_set_flags) ? in_flags : ccr_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (~main_valid_q | xfer) begin
      // Main slot frees up: the older skid entry has priority over the input.
      if (skid_valid_q) begin
        main_valid_d  = 1'b1;
        main_result_d = skid_result_q;
        main_rd_d     = skid_rd_q;
        main_wr_d     = skid_wr_q;
        main_taken_d  = skid_taken_q;
        skid_valid_d  = 1'b0;
      end else if (accept) begin
        main_valid_d  = 1'b1;
        main_result_d = in_result;
        main_rd_d     = in_rd;
        main_wr_d     = in_wr_reg;
        main_taken_d  = in_taken;
      end else begin
        main_valid_d  = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d  = 1'b1;
      skid_result_d = in_result;
      skid_rd_d     = in_rd;
      skid_wr_d     = in_wr_reg;
      skid_taken_d  = in_taken;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      ccr_q         <= '0;
      main_result_q <= '0;
      main_rd_q     <= '0;
      main_wr_q     <= 1'b0;
      main_taken_q  <= 1'b0;
    end else begin
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      ccr_q         <= ccr_d;
      main_result_q <= main_result_d;
      main_rd_q     <= main_rd_d;
      main_wr_q     <= main_wr_d;
      main_taken_q  <= main_taken_d;
    end
  end

  // Skid payload is only meaningful while skid_valid_q is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    skid_result_q <= skid_result_d;
    skid_rd_q     <= skid_rd_d;
    skid_wr_q     <= skid_wr_d;
    skid_taken_q  <= skid_taken_d;
  end

  assign out_valid  = main_valid_q;
  assign out_result = main_result_q;
  assign out_rd     = main_rd_q;
  assign out_wr_reg = main_valid_q & main_wr_q;
  assign out_taken  = main_taken_q;
  assign ccr_o      = ccr_q;

endmodule

// File: tb/tb_alu_wb.sv
// Self-checking bench for alu_wb: directed scenarios plus a randomized run, all
// checked against a queue-based model of the stage.
module tb_alu_wb;

  localparam int WIDTH = 32;
  localparam int REGW  = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_c, in_z, in_n, in_v;
  logic [REGW-1:0]  in_rd;
  logic             in_wr_reg, in_set_flags, in_is_branch;
  logic [3:0]       in_cond;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic [REGW-1:0]  out_rd;
  logic             out_wr_reg, out_taken;
  logic [3:0]       ccr_o;

  alu_wb #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_c         (in_c),
    .in_z         (in_z),
    .in_n         (in_n),
    .in_v         (in_v),
    .in_rd        (in_rd),
    .in_wr_reg    (in_wr_reg),
    .in_set_flags (in_set_flags),
    .in_is_branch (in_is_branch),
    .in_cond      (in_cond),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_wr_reg   (out_wr_reg),
    .out_taken    (out_taken),
    .ccr_o        (ccr_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [REGW-1:0]  rd;
    logic             wr;
    logic             taken;
  } exp_t;

  exp_t       mq[$];
  logic [3:0] mccr;

  // Branch rule table: flags are {C,Z,N,V}, "less than" signed is N != V.
  function automatic logic ref_taken(input logic [3:0] cond, input logic [3:0] f);
    logic c, z, lt;
    c  = f[3];
    z  = f[2];
    lt = (f[1] != f[0]);
    case (cond)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return c;
      4'd4:    return !c && !z;
      4'd5:    return c || z;
      4'd6:    return !c;
      4'd7:    return lt;
      4'd8:    return !z && !lt;
      4'd9:    return z || lt;
      4'd10:   return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_idle();
    in_valid     = 1'b0;
    in_result    = '0;
    {in_c, in_z, in_n, in_v} = 4'b0000;
    in_rd        = '0;
    in_wr_reg    = 1'b0;
    in_set_flags = 1'b0;
    in_is_branch = 1'b0;
    in_cond      = 4'd0;
  endtask

  task automatic drive_entry(input logic [WIDTH-1:0] r, input logic [3:0] f,
                             input logic [REGW-1:0] rd, input logic wr,
                             input logic setf, input logic br, input logic [3:0] cond);
    in_valid     = 1'b1;
    in_result    = r;
    {in_c, in_z, in_n, in_v} = f;
    in_rd        = rd;
    in_wr_reg    = wr;
    in_set_flags = setf;
    in_is_branch = br;
    in_cond      = cond;
  endtask

  task automatic drive_random_entry();
    drive_entry($urandom, 4'($urandom), REGW'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  // One clock: decide what the stage should do with the current inputs, then
  // apply it to the model at the edge.
  task automatic tick();
    logic       acc, xf;
    logic [3:0] f, eff;
    exp_t       e;
    f   = {in_c, in_z, in_n, in_v};
    acc = in_valid && !rst && !flush && (mq.size() < 2);
    xf  = (mq.size() > 0) && out_ready;
    eff = in_set_flags ? f : mccr;
    e.result = in_result;
    e.rd     = in_rd;
    e.wr     = in_wr_reg;
    e.taken  = in_is_branch && ref_taken(in_cond, eff);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mccr = 4'b0000;
    end else begin
      if (acc && in_set_flags) mccr = f;
      if (flush) mq.delete();
      else begin
        if (xf) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_idle();
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== '0 || out_rd !== '0 || out_wr_reg !== 1'b0 || out_taken !== 1'b0) begin
      failures++; $display("FAIL reset_out_fields got=%h/%h/%b/%b exp=0/0/0/0", out_result, out_rd, out_wr_reg, out_taken); end
    checks++; if (ccr_o !== 4'b0000) begin failures++; $display("FAIL reset_ccr got=%b exp=0000", ccr_o); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || ccr_o !== 4'b0000) begin
      failures++; $display("FAIL idle_after_reset got=%b/%b exp=0/0000", out_valid, ccr_o); end
  endtask

  task automatic test_ltu();
    logic [WIDTH-1:0] a, b, res;
    logic             bo, z, n, v;
    a = 5; b = 7;
    {bo, res} = {1'b0, a} - {1'b0, b};
    n = res[WIDTH-1];
    z = (res == '0);
    v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    out_ready = 1'b1;
    drive_entry(res, {bo, z, n, v}, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    checks++; if (ccr_o !== 4'b1010) begin failures++; $display("FAIL sub_ccr got=%b exp=1010", ccr_o); end
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE || out_rd !== 4'd3 || out_wr_reg !== 1'b1) begin
      failures++; $display("FAIL sub_out got=%b/%h/%h/%b exp=1/fffffffe/3/1", out_valid, out_result, out_rd, out_wr_reg); end
    drive_entry($urandom, 4'($urandom), 4'd4, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    checks++; if (out_taken !== 1'b1 || out_wr_reg !== 1'b0) begin
      failures++; $display("FAIL ltu_taken got=%b/%b exp=1/0", out_taken, out_wr_reg); end
    drive_entry($urandom, 4'($urandom), 4'd5, 1'b0, 1'b0, 1'b1, 4'd6);
    tick();
    checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL geu_not_taken got=%b exp=0", out_taken); end
    checks++; if (ccr_o !== 4'b1010) begin failures++; $display("FAIL ccr_held got=%b exp=1010", ccr_o); end
    drive_idle();
    tick();
  endtask

  task automatic test_forward();
    out_ready = 1'b1;
    drive_entry(32'd0, 4'b0100, 4'd1, 1'b1, 1'b1, 1'b1, 4'd1);
    tick();
    checks++; if (out_taken !== 1'b1) begin failures++; $display("FAIL fwd_taken got=%b exp=1", out_taken); end
    checks++; if (ccr_o !== 4'b0100) begin failures++; $display("FAIL fwd_ccr got=%b exp=0100", ccr_o); end
    drive_entry(32'd9, 4'b0000, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    checks++; if (ccr_o !== 4'b0000) begin failures++; $display("FAIL clear_ccr got=%b exp=0000", ccr_o); end
    drive_entry(32'd0, 4'b0100, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1);
    tick();
    checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL nofwd_taken got=%b exp=0", out_taken); end
    checks++; if (ccr_o !== 4'b0000) begin failures++; $display("FAIL nofwd_ccr got=%b exp=0000", ccr_o); end
    drive_idle();
    tick();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ent_res[4];
    logic [REGW-1:0]  ent_rd[4];
    int idx, oidx;
    for (int i = 0; i < 4; i++) begin
      ent_res[i] = $urandom;
      ent_rd[i]  = REGW'(i + 8);
    end
    idx = 0; oidx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 30 && oidx < 4; cyc++) begin
      if (cyc == 6) out_ready = 1'b1;
      if (idx < 4) drive_entry(ent_res[idx], 4'($urandom), ent_rd[idx], 1'b1, 1'b0, 1'b0, 4'd0);
      else drive_idle();
      #1;
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
      end
      if (cyc >= 1 && cyc < 6) begin
        checks++; if (out_valid !== 1'b1 || out_result !== ent_res[0]) begin
          failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_result, ent_res[0]); end
      end
      checks++; if (in_ready !== (mq.size() < 2)) begin
        failures++; $display("FAIL bp_in_ready got=%b exp=%b", in_ready, (mq.size() < 2)); end
      if (out_valid && out_ready) begin
        checks++; if (out_result !== ent_res[oidx] || out_rd !== ent_rd[oidx]) begin
          failures++; $display("FAIL bp_order idx=%0d got=%h/%h exp=%h/%h", oidx, out_result, out_rd, ent_res[oidx], ent_rd[oidx]); end
        oidx++;
      end
      if (idx < 4 && mq.size() < 2) idx++;
      tick();
    end
    checks++; if (oidx != 4 || idx != 4) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=4/4", oidx, idx); end
    drive_idle();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_entry(32'h11, 4'b1001, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    drive_entry(32'h22, 4'b0110, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    drive_entry(32'h33, 4'b1111, 4'd3, 1'b1, 1'b1, 1'b1, 4'd0);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0;
    drive_idle();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
    checks++; if (ccr_o !== 4'b0110) begin failures++; $display("FAIL flush_full_ccr got=%b exp=0110", ccr_o); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_recover got=%b exp=1", in_ready); end
    // Flush with only main occupied: the presented entry would otherwise be taken.
    drive_entry(32'h44, 4'b0011, 4'd4, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    drive_entry(32'h55, 4'b1100, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_idle();
    #1;
    checks++; if (out_valid !== 1'b0 || ccr_o !== 4'b0011) begin
      failures++; $display("FAIL flush_half got=%b/%b exp=0/0011", out_valid, ccr_o); end
    tick();
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] r;
    logic [3:0]       f, cond, eff;
    logic             setf, exp_tk;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r    = $urandom;
      f    = 4'($urandom);
      setf = 1'($urandom);
      cond = (i < 5) ? 4'(11 + i) : 4'($urandom_range(0, 15));
      eff  = setf ? f : mccr;
      exp_tk = (cond >= 4'd11) ? 1'b0 : ref_taken(cond, eff);
      drive_entry(r, f, REGW'(i), 1'b1, setf, 1'b1, cond);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_result !== r || out_rd !== REGW'(i) || out_taken !== exp_tk) begin
        failures++; $display("FAIL stream i=%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", i, out_valid, out_result, out_rd, out_taken, r, REGW'(i), exp_tk); end
    end
    drive_idle();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    exp_t e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) drive_random_entry();
      else drive_idle();
      #1;
      checks++; if (in_ready !== (!rst && !flush && mq.size() < 2)) begin
        failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (!rst && !flush && mq.size() < 2)); end
      checks++; if (out_valid !== (mq.size() > 0)) begin
        failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (mq.size() > 0)); end
      checks++; if (ccr_o !== mccr) begin failures++; $display("FAIL rnd_ccr cyc=%0d got=%b exp=%b", cyc, ccr_o, mccr); end
      if (mq.size() > 0) begin
        e = mq[0];
        checks++; if (out_result !== e.result || out_rd !== e.rd || out_wr_reg !== e.wr || out_taken !== e.taken) begin
          failures++; $display("FAIL rnd_data cyc=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", cyc, out_result, out_rd, out_wr_reg, out_taken, e.result, e.rd, e.wr, e.taken); end
      end else begin
        checks++; if (out_wr_reg !== 1'b0) begin failures++; $display("FAIL rnd_wr_qual cyc=%0d got=%b exp=0", cyc, out_wr_reg); end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_ltu();
    test_forward();
    test_backpressure();
    test_flush();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
